processor_controller: RTL and testbench



---
 rtl/proc_pkg.sv | 34 +++
 rtl/pc_ir_reg.sv | 35 +++
 rtl/processor_controller.sv | 121 ++++++++++++
 tb/tb_processor_controller.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared constants for the processor control unit: opcodes, FSM state codes,
// ALU select codes and default widths.
package proc_pkg;

    localparam int unsigned PC_W_DEF = 5;
    localparam int unsigned IW_DEF   = 16;

    localparam logic [3:0] OP_NOOP  = 4'h0;
    localparam logic [3:0] OP_STORE = 4'h1;
    localparam logic [3:0] OP_LOAD  = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_HALT  = 4'h5;
    localparam logic [3:0] OP_JUMP  = 4'h6;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;

    typedef enum logic [3:0] {
        ST_INIT   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_NOOP   = 4'd3,
        ST_LOADA  = 4'd4,
        ST_LOADB  = 4'd5,
        ST_STORE  = 4'd6,
        ST_ADD    = 4'd7,
        ST_SUB    = 4'd8,
        ST_HALT   = 4'd9,
        ST_JUMP   = 4'd10
    } state_t;

endpackage

// File: rtl/pc_ir_reg.sv
// Program counter and instruction register: IR load with PC increment on
// fetch, and a jump-load of the PC.
module pc_ir_reg
    import proc_pkg::*;
#(
    parameter int unsigned PC_W = PC_W_DEF,
    parameter int unsigned IW   = IW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ir_load,
    input  logic            pc_inc,
    input  logic            pc_load,
    input  logic [IW-1:0]   instr,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] pc,
    output logic [IW-1:0]   ir
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= '0;
            ir <= '0;
        end else begin
            if (ir_load)
                ir <= instr;
            // Increment wraps naturally at the top of the ROM.
            if (pc_inc)
                pc <= pc + PC_W'(1);
            else if (pc_load)
                pc <= target;
        end
    end

endmodule

// File: rtl/processor_controller.sv
// Moore control unit for the 16-bit processor: fetch/decode/execute sequencing
// and datapath control decode. Define PROC_JUMP_EN to enable the JUMP opcode.
module processor_controller
    import proc_pkg::*;
#(
    parameter int unsigned PC_W = PC_W_DEF,
    parameter int unsigned IW   = IW_DEF
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [IW-1:0]   Instr_In,
    output logic [PC_W-1:0] PC_Out,
    output logic [IW-1:0]   IR_Out,
    output logic [3:0]      StateO,
    output logic [7:0]      D_Addr,
    output logic            D_Wr,
    output logic            RF_s,
    output logic [3:0]      RF_W_addr,
    output logic            RF_W_en,
    output logic [3:0]      RF_Ra_addr,
    output logic [3:0]      RF_Rb_addr,
    output logic [2:0]      ALU_s0
);

    state_t     state;
    logic [3:0] opcode;
    logic       fetch;
    logic       jump_load;

    assign opcode = IR_Out[15:12];
    assign fetch  = (state == ST_FETCH);
    assign StateO = 4'(state);

`ifdef PROC_JUMP_EN
    assign jump_load = (state == ST_JUMP);
`else
    assign jump_load = 1'b0;
`endif

    function automatic state_t decode_op(input logic [3:0] op);
        state_t nxt;
        case (op)
            OP_STORE: nxt = ST_STORE;
            OP_LOAD:  nxt = ST_LOADA;
            OP_ADD:   nxt = ST_ADD;
            OP_SUB:   nxt = ST_SUB;
            OP_HALT:  nxt = ST_HALT;
`ifdef PROC_JUMP_EN
            OP_JUMP:  nxt = ST_JUMP;
`else
            OP_JUMP:  nxt = ST_NOOP;
`endif
            default:  nxt = ST_NOOP;
        endcase
        return nxt;
    endfunction

    pc_ir_reg #(
        .PC_W (PC_W),
        .IW   (IW)
    ) u_pc_ir (
        .clk     (Clk),
        .rst     (Reset),
        .ir_load (fetch),
        .pc_inc  (fetch),
        .pc_load (jump_load),
        .instr   (Instr_In),
        .target  (IR_Out[PC_W-1:0]),
        .pc      (PC_Out),
        .ir      (IR_Out)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= ST_INIT;
        end else begin
            case (state)
                ST_INIT:   state <= ST_FETCH;
                ST_FETCH:  state <= ST_DECODE;
                ST_DECODE: state <= decode_op(opcode);
                ST_LOADA:  state <= ST_LOADB;
                ST_HALT:   state <= ST_HALT;
                default:   state <= ST_FETCH;
            endcase
        end
    end

    // Controls depend only on the state register and IR, so a reset clears them at once.
    always_comb begin
        D_Addr     = '0;
        D_Wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_addr  = '0;
        RF_W_en    = 1'b0;
        RF_Ra_addr = '0;
        RF_Rb_addr = '0;
        ALU_s0     = ALU_PASS;
        case (state)
            ST_LOADA, ST_LOADB: begin
                D_Addr    = IR_Out[11:4];
                RF_s      = 1'b1;
                RF_W_addr = IR_Out[3:0];
                RF_W_en   = (state == ST_LOADB);
            end
            ST_STORE: begin
                D_Addr     = IR_Out[11:4];
                RF_Ra_addr = IR_Out[3:0];
                D_Wr       = 1'b1;
            end
            ST_ADD, ST_SUB: begin
                RF_Ra_addr = IR_Out[11:8];
                RF_Rb_addr = IR_Out[7:4];
                RF_W_addr  = IR_Out[3:0];
                RF_W_en    = 1'b1;
                ALU_s0     = (state == ST_ADD) ? ALU_ADD : ALU_SUB;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_processor_controller.sv
// Self-checking bench for processor_controller: directed scenarios plus a
// random program checked against an instruction-level reference model.
module tb_processor_controller;

    logic        Clk;
    logic        Reset;
    logic [15:0] Instr_In;
    logic [4:0]  PC_Out;
    logic [15:0] IR_Out;
    logic [3:0]  StateO;
    logic [7:0]  D_Addr;
    logic        D_Wr;
    logic        RF_s;
    logic [3:0]  RF_W_addr;
    logic        RF_W_en;
    logic [3:0]  RF_Ra_addr;
    logic [3:0]  RF_Rb_addr;
    logic [2:0]  ALU_s0;

    logic [15:0] rom [32];
    logic [25:0] ctl;
    logic [50:0] obs;
    int errors = 0;
    int checks = 0;

`ifdef PROC_JUMP_EN
    localparam bit JUMP_EN = 1'b1;
`else
    localparam bit JUMP_EN = 1'b0;
`endif

    assign Instr_In = rom[PC_Out];
    assign ctl = {D_Addr, D_Wr, RF_s, RF_W_addr, RF_W_en, RF_Ra_addr, RF_Rb_addr, ALU_s0};
    assign obs = {StateO, PC_Out, IR_Out, ctl};

    processor_controller dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Instr_In   (Instr_In),
        .PC_Out     (PC_Out),
        .IR_Out     (IR_Out),
        .StateO     (StateO),
        .D_Addr     (D_Addr),
        .D_Wr       (D_Wr),
        .RF_s       (RF_s),
        .RF_W_addr  (RF_W_addr),
        .RF_W_en    (RF_W_en),
        .RF_Ra_addr (RF_Ra_addr),
        .RF_Rb_addr (RF_Rb_addr),
        .ALU_s0     (ALU_s0)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic tick;
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic reset_pulse;
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic start(input logic [15:0] w);
        for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
        rom[0] = w;
        reset_pulse();
    endtask

    // Expected control vector for one execute state, from the instruction fields.
    function automatic logic [25:0] exp_ctl(input int st, input logic [15:0] ir);
        logic [7:0] da = ir[11:4];
        logic [3:0] ra = ir[11:8];
        logic [3:0] rb = ir[7:4];
        logic [3:0] rg = ir[3:0];
        case (st)
            4: return {da, 1'b0, 1'b1, rg, 1'b0, 4'h0, 4'h0, 3'b000};
            5: return {da, 1'b0, 1'b1, rg, 1'b1, 4'h0, 4'h0, 3'b000};
            6: return {da, 1'b1, 1'b0, 4'h0, 1'b0, rg, 4'h0, 3'b000};
            7: return {8'h00, 1'b0, 1'b0, rg, 1'b1, ra, rb, 3'b001};
            8: return {8'h00, 1'b0, 1'b0, rg, 1'b1, ra, rb, 3'b010};
            default: return 26'd0;
        endcase
    endfunction

    task automatic test_reset;
        @(negedge Clk);
        checks++; if (StateO !== 4'd0) begin errors++; $display("FAIL reset_state got %0d want 0", StateO); end
        checks++; if (PC_Out !== 5'd0) begin errors++; $display("FAIL reset_pc got %0d want 0", PC_Out); end
        checks++; if (IR_Out !== 16'h0) begin errors++; $display("FAIL reset_ir got %h want 0000", IR_Out); end
        checks++; if (ctl !== 26'd0) begin errors++; $display("FAIL reset_ctl got %h want 0", ctl); end
    endtask

    task automatic test_noop;
        int st [5] = '{0, 1, 2, 3, 1};
        int pc [5] = '{0, 0, 1, 1, 1};
        start(16'h0000);
        for (int i = 0; i < 5; i++) begin
            checks++; if (StateO !== 4'(st[i])) begin errors++; $display("FAIL noop_state[%0d] got %0d want %0d", i, StateO, st[i]); end
            checks++; if (PC_Out !== 5'(pc[i])) begin errors++; $display("FAIL noop_pc[%0d] got %0d want %0d", i, PC_Out, pc[i]); end
            checks++; if (ctl !== 26'd0) begin errors++; $display("FAIL noop_ctl[%0d] got %h want 0", i, ctl); end
            if (i < 4) tick();
        end
    endtask

    task automatic test_load;
        start(16'h21B0);
        repeat (3) tick();
        checks++; if (StateO !== 4'd4) begin errors++; $display("FAIL loada_state got %0d want 4", StateO); end
        checks++; if (D_Addr !== 8'h1B) begin errors++; $display("FAIL loada_daddr got %h want 1b", D_Addr); end
        checks++; if (RF_s !== 1'b1) begin errors++; $display("FAIL loada_rfs got %b want 1", RF_s); end
        checks++; if (RF_W_en !== 1'b0) begin errors++; $display("FAIL loada_wen got %b want 0", RF_W_en); end
        tick();
        checks++; if (StateO !== 4'd5) begin errors++; $display("FAIL loadb_state got %0d want 5", StateO); end
        checks++; if (RF_W_en !== 1'b1) begin errors++; $display("FAIL loadb_wen got %b want 1", RF_W_en); end
        checks++; if (RF_W_addr !== 4'd0) begin errors++; $display("FAIL loadb_waddr got %0d want 0", RF_W_addr); end
        checks++; if (D_Addr !== 8'h1B || RF_s !== 1'b1) begin errors++; $display("FAIL loadb_hold got daddr=%h rfs=%b want 1b/1", D_Addr, RF_s); end
        tick();
        checks++; if (StateO !== 4'd1) begin errors++; $display("FAIL load_next got %0d want 1", StateO); end
    endtask

    task automatic test_add_sub;
        logic [15:0] w [2] = '{16'h3125, 16'h4125};
        for (int k = 0; k < 2; k++) begin
            start(w[k]);
            repeat (3) tick();
            checks++; if (StateO !== 4'(7 + k)) begin errors++; $display("FAIL alu%0d_state got %0d want %0d", k, StateO, 7 + k); end
            checks++; if ({RF_Ra_addr, RF_Rb_addr, RF_W_addr} !== 12'h125) begin errors++; $display("FAIL alu%0d_regs got %h want 125", k, {RF_Ra_addr, RF_Rb_addr, RF_W_addr}); end
            checks++; if (ALU_s0 !== 3'(1 + k)) begin errors++; $display("FAIL alu%0d_sel got %b want %0d", k, ALU_s0, 1 + k); end
            checks++; if (RF_W_en !== 1'b1 || RF_s !== 1'b0 || D_Wr !== 1'b0) begin errors++; $display("FAIL alu%0d_strobes got wen=%b rfs=%b dwr=%b want 1/0/0", k, RF_W_en, RF_s, D_Wr); end
            tick();
            checks++; if (StateO !== 4'd1) begin errors++; $display("FAIL alu%0d_next got %0d want 1", k, StateO); end
        end
    endtask

    task automatic test_store;
        start(16'h1407);
        repeat (3) tick();
        checks++; if (StateO !== 4'd6) begin errors++; $display("FAIL store_state got %0d want 6", StateO); end
        checks++; if (D_Wr !== 1'b1) begin errors++; $display("FAIL store_dwr got %b want 1", D_Wr); end
        checks++; if (D_Addr !== 8'h40) begin errors++; $display("FAIL store_daddr got %h want 40", D_Addr); end
        checks++; if (RF_Ra_addr !== 4'd7) begin errors++; $display("FAIL store_ra got %0d want 7", RF_Ra_addr); end
        checks++; if (RF_W_en !== 1'b0) begin errors++; $display("FAIL store_wen got %b want 0", RF_W_en); end
        // Reset in the middle of the store cycle must drop the strobe before any edge.
        Reset = 1'b1;
        #1;
        checks++; if (D_Wr !== 1'b0) begin errors++; $display("FAIL store_abort_dwr got %b want 0", D_Wr); end
        checks++; if (obs !== 51'd0) begin errors++; $display("FAIL store_abort_all got %h want 0", obs); end
        Reset = 1'b0;
    endtask

    task automatic test_halt;
        start(16'h5000);
        repeat (3) tick();
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (StateO !== 4'd9 || PC_Out !== 5'd1 || IR_Out !== 16'h5000) begin
                errors++;
                $display("FAIL halt[%0d] got st=%0d pc=%0d ir=%h want 9/1/5000", i, StateO, PC_Out, IR_Out);
            end
            tick();
        end
        #2;
        Reset = 1'b1;
        #1;
        checks++; if (obs !== 51'd0) begin errors++; $display("FAIL halt_reset got %h want 0", obs); end
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic test_jump;
        start(16'h6003);
        rom[3] = 16'h3125;
        repeat (3) tick();
`ifdef PROC_JUMP_EN
        checks++; if (StateO !== 4'd10 || PC_Out !== 5'd1 || ctl !== 26'd0) begin errors++; $display("FAIL jump_state got st=%0d pc=%0d ctl=%h want 10/1/0", StateO, PC_Out, ctl); end
        tick();
        checks++; if (StateO !== 4'd1 || PC_Out !== 5'd3) begin errors++; $display("FAIL jump_fetch got st=%0d pc=%0d want 1/3", StateO, PC_Out); end
        tick();
        checks++; if (IR_Out !== 16'h3125 || PC_Out !== 5'd4) begin errors++; $display("FAIL jump_target got ir=%h pc=%0d want 3125/4", IR_Out, PC_Out); end
`else
        checks++; if (StateO !== 4'd3 || PC_Out !== 5'd1) begin errors++; $display("FAIL jump_as_noop got st=%0d pc=%0d want 3/1", StateO, PC_Out); end
        tick();
        checks++; if (StateO !== 4'd1 || PC_Out !== 5'd1) begin errors++; $display("FAIL jump_as_noop_fetch got st=%0d pc=%0d want 1/1", StateO, PC_Out); end
        tick();
        checks++; if (IR_Out !== 16'h0000 || PC_Out !== 5'd2) begin errors++; $display("FAIL jump_as_noop_next got ir=%h pc=%0d want 0000/2", IR_Out, PC_Out); end
`endif
    endtask

    // Random program (no HALT) run against an instruction-level model of the ISA.
    task automatic test_random(input int n_instr);
        logic [50:0] q [$];
        logic [15:0] w;
        logic [4:0]  mpc = 5'd0;
        logic [15:0] mir = 16'h0000;
        int          sts [$];
        for (int i = 0; i < 32; i++) begin
            do w = 16'($urandom); while (w[15:12] == 4'h5);
            rom[i] = w;
        end
        q.push_back(51'd0);
        for (int k = 0; k < n_instr; k++) begin
            w = rom[mpc];
            q.push_back({4'd1, mpc, mir, 26'd0});
            mpc = mpc + 5'd1;
            mir = w;
            q.push_back({4'd2, mpc, mir, 26'd0});
            sts.delete();
            case (mir[15:12])
                4'h1: sts.push_back(6);
                4'h2: begin sts.push_back(4); sts.push_back(5); end
                4'h3: sts.push_back(7);
                4'h4: sts.push_back(8);
                4'h6: sts.push_back(JUMP_EN ? 10 : 3);
                default: sts.push_back(3);
            endcase
            foreach (sts[j]) q.push_back({4'(sts[j]), mpc, mir, exp_ctl(sts[j], mir)});
            if (mir[15:12] == 4'h6 && JUMP_EN) mpc = mir[4:0];
        end
        reset_pulse();
        for (int i = 0; i < q.size(); i++) begin
            checks++;
            if (obs !== q[i]) begin
                errors++;
                $display("FAIL random cycle %0d got st=%0d pc=%0d ir=%h ctl=%h want st=%0d pc=%0d ir=%h ctl=%h",
                         i, obs[50:47], obs[46:42], obs[41:26], obs[25:0],
                         q[i][50:47], q[i][46:42], q[i][41:26], q[i][25:0]);
            end
            if (i < q.size() - 1) tick();
        end
    endtask

    initial begin
        Reset = 1'b1;
        for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
        test_reset();
        test_noop();
        test_load();
        test_add_sub();
        test_store();
        test_halt();
        test_jump();
        test_random(80);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
